// File: rtl/mole_ctrl.sv
// Whack-a-mole round controller: picks a hole from the LFSR value, lights it
// for a bounded time, judges key presses, and keeps score, lives and rounds.
module mole_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int SHOW_TICKS = 800,
  parameter int GAP_TICKS  = 300,
  parameter int LIVES      = 3,
  parameter int ROUNDS     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] rnd,
  input  logic [7:0] key,
  output logic [7:0] mole,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic [7:0] round_cnt,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [PW-1:0] DIV_LAST   = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]    ROUNDS_END = 8'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PICK = 3'd1,
    SHOW = 3'd2,
    GAP  = 3'd3,
    OVER = 3'd4
  } state_t;

  state_t        state_q;
  logic [7:0]    mole_q;
  logic [7:0]    score_q;
  logic [2:0]    lives_q;
  logic [7:0]    round_q;
  logic          hit_q;
  logic          miss_q;
  logic [2:0]    last_hole_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] timer_q;

  logic [2:0]    hole_d;
  logic [7:0]    round_d;
  logic          tick;
  logic          show_done;
  logic          gap_done;
  logic          key_hit;
  logic          key_any;

  // Tick strobe and end-of-phase detection; the timer counts completed ticks,
  // so a phase ends on the tick that would bring it to its tick budget.
  assign tick      = (presc_q == DIV_LAST);
  assign show_done = tick && (timer_q == SHOW_LAST);
  assign gap_done  = tick && (timer_q == GAP_LAST);
  assign key_hit   = |(key & mole_q);
  assign key_any   = |key;
  assign round_d   = round_q + 8'd1;

  // Candidate hole from the random value, bumped by one to avoid lighting the
  // same hole twice in a row.
  always_comb begin
    hole_d = rnd[2:0];
    if (hole_d == last_hole_q) begin
      hole_d = hole_d + 3'd1;
    end
  end

  // Game FSM with all outputs registered; later assignments in a branch
  // override the default timer advance when a phase is entered or left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mole_q      <= 8'd0;
      score_q     <= 8'd0;
      lives_q     <= LIVES_INIT;
      round_q     <= 8'd0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      last_hole_q <= 3'd0;
      presc_q     <= '0;
      timer_q     <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;

      if (state_q == SHOW || state_q == GAP) begin
        if (tick) begin
          presc_q <= '0;
          timer_q <= timer_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
        timer_q <= '0;
      end

      case (state_q)
        IDLE, OVER: begin
          mole_q <= 8'd0;
          if (start) begin
            score_q <= 8'd0;
            lives_q <= LIVES_INIT;
            round_q <= 8'd0;
            state_q <= PICK;
          end
        end

        PICK: begin
          mole_q <= 8'd0;
          if (rnd != 4'd0) begin
            mole_q      <= 8'd1 << hole_d;
            last_hole_q <= hole_d;
            presc_q     <= '0;
            timer_q     <= '0;
            state_q     <= SHOW;
          end
        end

        SHOW: begin
          if (key_hit) begin
            if (score_q != 8'hFF) begin
              score_q <= score_q + 8'd1;
            end
            hit_q   <= 1'b1;
            mole_q  <= 8'd0;
            presc_q <= '0;
            timer_q <= '0;
            state_q <= GAP;
          end else if (key_any || show_done) begin
            if (lives_q != 3'd0) begin
              lives_q <= lives_q - 3'd1;
            end
            miss_q  <= 1'b1;
            mole_q  <= 8'd0;
            presc_q <= '0;
            timer_q <= '0;
            state_q <= GAP;
          end
        end

        GAP: begin
          mole_q <= 8'd0;
          if (gap_done) begin
            round_q <= round_d;
            presc_q <= '0;
            timer_q <= '0;
            if (lives_q == 3'd0 || round_d == ROUNDS_END) begin
              state_q <= OVER;
            end else begin
              state_q <= PICK;
            end
          end
        end

        default: begin
          mole_q  <= 8'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign round_cnt  = round_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign game_over  = (state_q == OVER);
  assign state      = state_q;

endmodule
